// File: rtl/phasecalc_pkg.sv
// Shared types and constants for the phase-calc I/Q accumulation path.
// Contents: FSM state enum, quadrant codes, per-phase I/Q coefficient tables,
// and a quadrant classification helper.
package phasecalc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Coefficient selector for one MAC slice: +1, 0 or -1.
  typedef enum logic [1:0] {
    COEF_ZERO = 2'd0,
    COEF_POS  = 2'd1,
    COEF_NEG  = 2'd2
  } coef_t;

  localparam logic [1:0] QUAD_IPOS_QPOS = 2'd0;
  localparam logic [1:0] QUAD_INEG_QPOS = 2'd1;
  localparam logic [1:0] QUAD_INEG_QNEG = 2'd2;
  localparam logic [1:0] QUAD_IPOS_QNEG = 2'd3;

  // Index is the 2-bit phase; element 0 is phase 0.
  localparam coef_t I_COEF [4] = '{COEF_POS, COEF_ZERO, COEF_NEG, COEF_ZERO};
  localparam coef_t Q_COEF [4] = '{COEF_ZERO, COEF_POS, COEF_ZERO, COEF_NEG};

  // Quadrant code from the sign bits of the I and Q sums.
  function automatic logic [1:0] quadrant_of(input logic i_neg, input logic q_neg);
    logic [1:0] code;
    if (!i_neg && !q_neg)     code = QUAD_IPOS_QPOS;
    else if (i_neg && !q_neg) code = QUAD_INEG_QPOS;
    else if (i_neg && q_neg)  code = QUAD_INEG_QNEG;
    else                      code = QUAD_IPOS_QNEG;
    return code;
  endfunction

endpackage

// File: rtl/phase_iq_accumulator_iq_mac.sv
// iq_mac: one signed add-with-coefficient slice (acc + coef*sample, coef in
// {+1,0,-1}) with signed-overflow detect. Purely combinational.
// Build option: PHASE_IQ_SAT_EN defined -> result clamps to the signed ACC_W
// range on overflow; undefined -> two's-complement wrap. ovf_c flags overflow
// in both builds.
// Ports:
//   acc     in  ACC_W   current accumulator value
//   sample  in  DATA_W  signed input sample
//   coef    in  coef_t  coefficient selector
//   sum_c   out ACC_W   next accumulator value
//   ovf_c   out 1       signed overflow on this add
module iq_mac
  import phasecalc_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ACC_W  = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] sample,
  input  coef_t                    coef,
  output logic signed [ACC_W-1:0]  sum_c,
  output logic                     ovf_c
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] addend;
  logic signed [SUM_W-1:0] wide;

  // Extend before negating so the most negative sample negates exactly.
  always_comb begin
    ext = {{(ACC_W - DATA_W){sample[DATA_W-1]}}, sample};
    unique case (coef)
      COEF_POS: addend = ext;
      COEF_NEG: addend = -ext;
      default:  addend = '0;
    endcase
    wide  = SUM_W'(acc) + SUM_W'(addend);
    // One guard bit: overflow when it disagrees with the result sign.
    ovf_c = wide[ACC_W] ^ wide[ACC_W-1];
`ifdef PHASE_IQ_SAT_EN
    if (ovf_c) begin
      sum_c = wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end else begin
      sum_c = wide[ACC_W-1:0];
    end
`else
    sum_c = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/phase_iq_accumulator.sv
// phase_iq_accumulator: consumer of the phase-calc sequencer start/enable
// handshake. Demodulates the signed sample stream with a 4-phase quadrature
// coefficient sequence over the enable window and presents I/Q sums plus a
// quadrant code on a valid/ready output.
// Build option: PHASE_IQ_SAT_EN (saturating accumulators, see iq_mac).
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   start, enable         sequencer window strobe / sample qualifier
//   sample_in             signed sample, taken when enable=1
//   out_ready             downstream accepts result
//   out_valid             result presented
//   i_sum, q_sum          signed I/Q sums
//   quadrant              sign quadrant of (i_sum, q_sum)
//   sample_count          samples accumulated in the presented result
//   busy                  window accumulation in progress
//   ovf                   accumulator overflow in the presented window
//   overrun               sticky: unconsumed result discarded by a new start
module phase_iq_accumulator
  import phasecalc_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned MAX_SAMPLES = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 enable,
  input  logic signed [DATA_W-1:0]             sample_in,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic signed [ACC_W-1:0]              i_sum,
  output logic signed [ACC_W-1:0]              q_sum,
  output logic [1:0]                           quadrant,
  output logic [$clog2(MAX_SAMPLES + 1)-1:0]   sample_count,
  output logic                                 busy,
  output logic                                 ovf,
  output logic                                 overrun
);

  localparam int unsigned CNT_W = $clog2(MAX_SAMPLES + 1);

  state_t                  state, state_n;
  logic signed [ACC_W-1:0] acc_i, acc_i_n, acc_q, acc_q_n;
  logic [1:0]              phase, phase_n;
  logic [CNT_W-1:0]        n_cnt, n_cnt_n;
  logic                    win_ovf, win_ovf_n;

  logic                    out_valid_n, busy_n, ovf_n, overrun_n;
  logic signed [ACC_W-1:0] i_sum_n, q_sum_n;
  logic [1:0]              quadrant_n;
  logic [CNT_W-1:0]        sample_count_n;

  logic                    restart;
  logic [1:0]              coef_idx;
  logic signed [ACC_W-1:0] mac_acc_i, mac_acc_q, sum_i, sum_q;
  logic                    ovf_i, ovf_q;

  // A start starts a fresh window from any state: MACs see zero and phase 0.
  assign restart   = start & enable;
  assign coef_idx  = restart ? 2'd0 : phase;
  assign mac_acc_i = restart ? '0 : acc_i;
  assign mac_acc_q = restart ? '0 : acc_q;

  iq_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_i (
    .acc    (mac_acc_i),
    .sample (sample_in),
    .coef   (I_COEF[coef_idx]),
    .sum_c  (sum_i),
    .ovf_c  (ovf_i)
  );

  iq_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_q (
    .acc    (mac_acc_q),
    .sample (sample_in),
    .coef   (Q_COEF[coef_idx]),
    .sum_c  (sum_q),
    .ovf_c  (ovf_q)
  );

  // Next-state, counters and result register updates.
  always_comb begin
    state_n        = state;
    acc_i_n        = acc_i;
    acc_q_n        = acc_q;
    phase_n        = phase;
    n_cnt_n        = n_cnt;
    win_ovf_n      = win_ovf;
    i_sum_n        = i_sum;
    q_sum_n        = q_sum;
    quadrant_n     = quadrant;
    sample_count_n = sample_count;
    ovf_n          = ovf;
    overrun_n      = overrun;

    unique case (state)
      IDLE: ;
      ACC: begin
        if (!restart) begin
          if (enable) begin
            // Samples past MAX_SAMPLES are ignored; phase holds too.
            if (n_cnt < CNT_W'(MAX_SAMPLES)) begin
              acc_i_n   = sum_i;
              acc_q_n   = sum_q;
              phase_n   = phase + 2'd1;
              n_cnt_n   = n_cnt + CNT_W'(1);
              win_ovf_n = win_ovf | ovf_i | ovf_q;
            end
          end else begin
            i_sum_n        = acc_i;
            q_sum_n        = acc_q;
            quadrant_n     = quadrant_of(acc_i[ACC_W-1], acc_q[ACC_W-1]);
            sample_count_n = n_cnt;
            ovf_n          = win_ovf;
            state_n        = DONE;
          end
        end
      end
      DONE: begin
        // Start outranks out_ready; the pending result is dropped.
        if (restart) begin
          overrun_n = 1'b1;
        end else if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (restart) begin
      state_n   = ACC;
      acc_i_n   = sum_i;
      acc_q_n   = sum_q;
      phase_n   = 2'd1;
      n_cnt_n   = CNT_W'(1);
      win_ovf_n = ovf_i | ovf_q;
    end

    out_valid_n = (state_n == DONE);
    busy_n      = (state_n == ACC);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      acc_i        <= '0;
      acc_q        <= '0;
      phase        <= '0;
      n_cnt        <= '0;
      win_ovf      <= 1'b0;
      out_valid    <= 1'b0;
      i_sum        <= '0;
      q_sum        <= '0;
      quadrant     <= '0;
      sample_count <= '0;
      busy         <= 1'b0;
      ovf          <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      acc_i        <= acc_i_n;
      acc_q        <= acc_q_n;
      phase        <= phase_n;
      n_cnt        <= n_cnt_n;
      win_ovf      <= win_ovf_n;
      out_valid    <= out_valid_n;
      i_sum        <= i_sum_n;
      q_sum        <= q_sum_n;
      quadrant     <= quadrant_n;
      sample_count <= sample_count_n;
      busy         <= busy_n;
      ovf          <= ovf_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_phase_iq_accumulator.sv
// Scoreboard bench for phase_iq_accumulator: the driver pushes hand-computed
// expected results as it issues each window; a monitor pops and compares on
// every out_valid rise and re-checks stability while the result is held.
// A second instance with ACC_W=14 covers the overflow/saturation case.
module tb_phase_iq_accumulator;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned ACC14       = 14;
  localparam int unsigned MAX_SAMPLES = 16;
  localparam int unsigned CNT_W       = $clog2(MAX_SAMPLES + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic enable = 1'b0;
  logic out_ready = 1'b1;
  logic ready_14 = 1'b1;
  logic signed [DATA_W-1:0] sample_in = '0;

  logic                    out_valid, busy, ovf, overrun;
  logic signed [ACC_W-1:0] i_sum, q_sum;
  logic [1:0]              quadrant;
  logic [CNT_W-1:0]        sample_count;

  logic                    out_valid_14, busy_14, ovf_14, overrun_14;
  logic signed [ACC14-1:0] i_sum_14, q_sum_14;
  logic [1:0]              quadrant_14;
  logic [CNT_W-1:0]        sample_count_14;

  phase_iq_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_SAMPLES(MAX_SAMPLES)) dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .sample_in(sample_in), .out_ready(out_ready), .out_valid(out_valid),
    .i_sum(i_sum), .q_sum(q_sum), .quadrant(quadrant),
    .sample_count(sample_count), .busy(busy), .ovf(ovf), .overrun(overrun)
  );

  phase_iq_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC14), .MAX_SAMPLES(MAX_SAMPLES)) dut14 (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .sample_in(sample_in), .out_ready(ready_14), .out_valid(out_valid_14),
    .i_sum(i_sum_14), .q_sum(q_sum_14), .quadrant(quadrant_14),
    .sample_count(sample_count_14), .busy(busy_14), .ovf(ovf_14), .overrun(overrun_14)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint e_i;
    longint e_q;
    int     e_quad;
    int     e_cnt;
    int     e_ovf;
    int     e_ovr;
    int     e_rise;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind 0: constant amp; 1: cosine amp,0,-amp,0; 2: sine 0,amp,0,-amp; 3: ramp k+1
  function automatic int sval(input int kind, input int amp, input int k);
    int v;
    case (kind)
      0:       v = amp;
      1:       v = (k % 4 == 0) ? amp : ((k % 4 == 2) ? -amp : 0);
      2:       v = (k % 4 == 1) ? amp : ((k % 4 == 3) ? -amp : 0);
      default: v = k + 1;
    endcase
    return v;
  endfunction

  // Sequencer-style window: start+enable, n-1 more enables, then enable low.
  task automatic drive_window(input int n, input int kind, input int amp,
                              input longint ei, input longint eq, input int equad,
                              input int ecnt, input int eovf, input int eovr);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      if (k == 0) begin
        e.e_i = ei; e.e_q = eq; e.e_quad = equad; e.e_cnt = ecnt;
        e.e_ovf = eovf; e.e_ovr = eovr; e.e_rise = cyc + n + 1;
        sb.push_back(e);
      end
      start     = (k == 0);
      enable    = 1'b1;
      sample_in = DATA_W'(sval(kind, amp, k));
    end
    @(posedge clock); #1;
    start     = 1'b0;
    enable    = 1'b0;
    sample_in = '0;
  endtask

  task automatic wait_pop(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clock);
      t++;
    end
    chk(name, longint'(sb.size()), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_i_sum"}, longint'(i_sum), 0);
    chk({tag, "_q_sum"}, longint'(q_sum), 0);
    chk({tag, "_quadrant"}, longint'(quadrant), 0);
    chk({tag, "_sample_count"}, longint'(sample_count), 0);
    chk({tag, "_ovf"}, longint'(ovf), 0);
    chk({tag, "_overrun"}, longint'(overrun), 0);
  endtask

  // Monitor: pop on out_valid rise, compare every cycle the result is held.
  initial begin : monitor
    bit   have = 1'b0;
    bit   pv = 1'b0;
    bit   pacc = 1'b0;
    exp_t cur;
    forever begin
      @(negedge clock);
      if (reset) begin
        have = 1'b0;
        pacc = 1'b0;
      end else begin
        if (pacc) chk("accept_then_valid_low", longint'(out_valid), 0);
        if (out_valid && !pv) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", longint'(out_valid), 0);
            have = 1'b0;
          end else begin
            cur  = sb.pop_front();
            have = 1'b1;
            chk("valid_rise_cycle", longint'(cyc), longint'(cur.e_rise));
          end
        end
        if (out_valid && have) begin
          chk("i_sum", longint'(i_sum), cur.e_i);
          chk("q_sum", longint'(q_sum), cur.e_q);
          chk("quadrant", longint'(quadrant), longint'(cur.e_quad));
          chk("sample_count", longint'(sample_count), longint'(cur.e_cnt));
          chk("ovf", longint'(ovf), longint'(cur.e_ovf));
          chk("overrun", longint'(overrun), longint'(cur.e_ovr));
          chk("busy_in_done", longint'(busy), 0);
        end
        pacc = out_valid && out_ready && !(start && enable);
      end
      pv = out_valid;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int t;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Constant 100 x9 with sequencer timing.
    drive_window(9, 0, 100, 100, 0, 0, 9, 0, 0);
    wait_pop("t1_result");
    repeat (2) @(posedge clock);

    // Cosine, sine, negated cosine.
    drive_window(9, 1, 10, 50, 0, 0, 9, 0, 0);
    wait_pop("t2_cos");
    repeat (2) @(posedge clock);
    drive_window(9, 2, 10, 0, 40, 0, 9, 0, 0);
    wait_pop("t2_sin");
    repeat (2) @(posedge clock);
    drive_window(9, 1, -10, -50, 0, 1, 9, 0, 0);
    wait_pop("t2_negcos");
    repeat (2) @(posedge clock);

    // Backpressure: result held 5 cycles, then accepted.
    out_ready = 1'b0;
    drive_window(5, 0, -30, -30, 0, 1, 5, 0, 0);
    wait_pop("t3_result");
    repeat (5) @(posedge clock);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("t3_idle_valid", longint'(out_valid), 0);
    chk("t3_idle_busy", longint'(busy), 0);

    // Overflow on the 14-bit instance: 5 I contributions of 2047.
    drive_window(9, 1, 2047, 10235, 0, 0, 9, 0, 0);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!out_valid_14 && t < 6);
    chk("t5_valid_14", longint'(out_valid_14), 1);
`ifdef PHASE_IQ_SAT_EN
    chk("t5_i_sum_14", longint'(i_sum_14), 8191);
    chk("t5_quadrant_14", longint'(quadrant_14), 0);
`else
    chk("t5_i_sum_14", longint'(i_sum_14), -6149);
    chk("t5_quadrant_14", longint'(quadrant_14), 1);
`endif
    chk("t5_q_sum_14", longint'(q_sum_14), 0);
    chk("t5_ovf_14", longint'(ovf_14), 1);
    chk("t5_count_14", longint'(sample_count_14), 9);
    chk("t5_busy_14", longint'(busy_14), 0);
    chk("t5_overrun_14", longint'(overrun_14), 0);
    wait_pop("t5_result");
    repeat (2) @(posedge clock);

    // 20 enables of ramp 1..20: only the first 16 are summed.
    drive_window(20, 3, 0, -8, -8, 2, 16, 0, 0);
    wait_pop("t6_max_samples");
    repeat (2) @(posedge clock);

    // Start while a result is pending: overrun, old result dropped.
    out_ready = 1'b0;
    drive_window(9, 0, 100, 100, 0, 0, 9, 0, 0);
    wait_pop("t4_first");
    drive_window(9, 2, 10, 0, 40, 0, 9, 0, 1);
    wait_pop("t4_second");
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("t4_overrun_sticky", longint'(overrun), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_zero("t4_after_reset");

    // Reset in the middle of a window: no result appears.
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      start     = (k == 0);
      enable    = 1'b1;
      sample_in = DATA_W'(50);
    end
    @(negedge clock);
    chk("t6_busy_mid_window", longint'(busy), 1);
    @(posedge clock); #1;
    reset  = 1'b1;
    start  = 1'b0;
    enable = 1'b0;
    sample_in = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    check_zero("t6_mid_reset");
    chk("final_queue_empty", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
